// File: rtl/axil_ctrl_regs.sv
// axil_ctrl_regs: AXI4-Lite register bank driving NUM_CH capture channels and the PL-to-PS irq.
// Define AXIL_CTRL_REGS_TIMESTAMP_EN to add a 64-bit timestamp readable coherently at 0x30/0x34.
module axil_ctrl_regs #(
    parameter int          ADDR_W   = 12,
    parameter int          NUM_CH   = 4,
    parameter int          CFG_W    = 16,
    parameter logic [31:0] ID_VALUE = 32'h4447_0001
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [ADDR_W-1:0]       s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_W-1:0]       s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [NUM_CH-1:0]       ch_enable,
    output logic [NUM_CH-1:0]       ch_start,
    output logic [NUM_CH*CFG_W-1:0] ch_cfg,
    input  logic [NUM_CH-1:0]       ch_busy,
    input  logic [NUM_CH-1:0]       ch_done,
    output logic                    irq
);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXIL_CTRL_REGS_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
    logic [63:0] ts_cnt;
    logic [31:0] ts_shadow;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_WAIT_A, W_WAIT_D, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic              live;
    logic              aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0] aw_addr_q, w_addr;
    logic [31:0]       wdata_q, w_data, w_mask, rd_data;
    logic [3:0]        wstrb_q, w_strb;
    logic [5:0]        w_idx, r_idx;
    logic [NUM_CH-1:0] irq_en, irq_stat, w1c_clr;
    logic [CFG_W-1:0]  cfg_q [NUM_CH];
    logic              unused;

    function automatic logic is_mapped(input logic [5:0] i);
        return i < 6'(4 + NUM_CH) || i == 6'd15 || (TS_EN && (i == 6'd12 || i == 6'd13));
    endfunction

    // Ready outputs stay low until the first clock after reset so nothing handshakes during reset.
    always_comb begin
        s_axi_awready = live && (w_state == W_IDLE || w_state == W_WAIT_A);
        s_axi_wready  = live && (w_state == W_IDLE || w_state == W_WAIT_D);
        s_axi_bvalid  = w_state == W_RESP;
        aw_hs         = s_axi_awvalid && s_axi_awready;
        w_hs          = s_axi_wvalid && s_axi_wready;
        commit        = (aw_hs || w_state == W_WAIT_D) && (w_hs || w_state == W_WAIT_A);
        w_next        = commit ? W_RESP :
                        aw_hs  ? W_WAIT_D :
                        w_hs   ? W_WAIT_A :
                        (w_state == W_RESP && s_axi_bready) ? W_IDLE : w_state;
        w_addr        = w_state == W_WAIT_D ? aw_addr_q : s_axi_awaddr;
        w_data        = w_state == W_WAIT_A ? wdata_q : s_axi_wdata;
        w_strb        = w_state == W_WAIT_A ? wstrb_q : s_axi_wstrb;
        w_idx         = w_addr[7:2];
        w_mask        = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
        w1c_clr       = (commit && w_idx == 6'd3 && w_strb[0]) ? w_data[NUM_CH-1:0] : '0;
    end

    always_comb begin
        s_axi_arready = live && r_state == R_IDLE;
        s_axi_rvalid  = r_state == R_RESP;
        ar_hs         = s_axi_arvalid && s_axi_arready;
        r_next        = ar_hs ? R_RESP : (s_axi_rvalid && s_axi_rready) ? R_IDLE : r_state;
        r_idx         = s_axi_araddr[7:2];
        rd_data       = r_idx == 6'd0  ? 32'(ch_enable) :
                        r_idx == 6'd1  ? 32'(ch_busy) :
                        r_idx == 6'd2  ? 32'(irq_en) :
                        r_idx == 6'd3  ? 32'(irq_stat) :
                        r_idx == 6'd15 ? ID_VALUE : '0;
        for (int n = 0; n < NUM_CH; n++)
            if (r_idx == 6'(4 + n)) rd_data = 32'(cfg_q[n]);
`ifdef AXIL_CTRL_REGS_TIMESTAMP_EN
        if (r_idx == 6'd12) rd_data = ts_cnt[31:0];
        if (r_idx == 6'd13) rd_data = ts_shadow;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            live        <= 1'b0;
            w_state     <= W_IDLE;
            r_state     <= R_IDLE;
            aw_addr_q   <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s_axi_bresp <= OKAY;
            s_axi_rdata <= '0;
            s_axi_rresp <= OKAY;
        end else begin
            live    <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
            if (aw_hs) aw_addr_q <= s_axi_awaddr;
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (commit) s_axi_bresp <= is_mapped(w_idx) ? OKAY : SLVERR;
            if (ar_hs) begin
                s_axi_rdata <= rd_data;
                s_axi_rresp <= is_mapped(r_idx) ? OKAY : SLVERR;
            end
        end
    end

    // A done pulse in the same cycle as a W1C clear keeps the bit set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ch_enable <= '0;
            ch_start  <= '0;
            irq_en    <= '0;
            irq_stat  <= '0;
            irq       <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) cfg_q[n] <= '0;
        end else begin
            if (commit && w_idx == 6'd0 && w_strb[0]) ch_enable <= w_data[NUM_CH-1:0];
            if (commit && w_idx == 6'd2 && w_strb[0]) irq_en <= w_data[NUM_CH-1:0];
            ch_start <= (commit && w_idx == 6'd0 && w_strb[1]) ? w_data[8 +: NUM_CH] : '0;
            irq_stat <= (irq_stat & ~w1c_clr) | ch_done;
            irq      <= |(irq_stat & irq_en);
            for (int n = 0; n < NUM_CH; n++)
                if (commit && w_idx == 6'(4 + n))
                    cfg_q[n] <= (cfg_q[n] & ~w_mask[CFG_W-1:0]) | (w_data[CFG_W-1:0] & w_mask[CFG_W-1:0]);
        end
    end

`ifdef AXIL_CTRL_REGS_TIMESTAMP_EN
    // Reading TS_LO snapshots the upper word so a following TS_HI read matches it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ts_cnt    <= '0;
            ts_shadow <= '0;
        end else begin
            ts_cnt <= ts_cnt + 64'd1;
            if (ar_hs && r_idx == 6'd12) ts_shadow <= ts_cnt[63:32];
        end
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cfg
        assign ch_cfg[i*CFG_W +: CFG_W] = cfg_q[i];
    end

    assign unused = ^{w_addr, w_data, w_mask, s_axi_araddr};
endmodule

// File: tb/tb_axil_ctrl_regs.sv
// tb_axil_ctrl_regs: randomized AXI4-Lite traffic against a transaction-level model of the register bank.
module tb_axil_ctrl_regs;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
    logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic [3:0]  ch_enable, ch_start, ch_busy = '0, ch_done;
    logic [3:0]  done_force = '0, done_rand = '0;
    logic [63:0] ch_cfg;
    logic        irq;

    always #5 clk = ~clk;
    assign ch_done = done_force | done_rand;

    axil_ctrl_regs #(.ADDR_W(12), .NUM_CH(4), .CFG_W(16), .ID_VALUE(32'h4447_0001)) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .ch_enable(ch_enable),
        .ch_start(ch_start), .ch_cfg(ch_cfg), .ch_busy(ch_busy), .ch_done(ch_done), .irq(irq)
    );

    int n_chk = 0, n_pass = 0;
    bit chk_on = 1'b0, rand_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: committed writes are posted by the driver for a known edge number.
    int          cyc = 0, c_at = -1;
    logic [11:0] c_addr = '0;
    logic [31:0] c_data = '0;
    logic [3:0]  c_strb = '0;
    logic [3:0]  m_en = '0, m_ien = '0, m_stat = '0, m_start = '0, m_clr;
    logic        m_irq = 1'b0, m_nirq, m_commit;
    logic [5:0]  m_idx;
    logic [15:0] m_cfg [4] = '{default: '0};

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!resetn) begin
            m_en = '0; m_ien = '0; m_stat = '0; m_start = '0; m_irq = 1'b0;
            for (int i = 0; i < 4; i++) m_cfg[i] = '0;
        end else begin
            m_commit = cyc == c_at;
            m_idx    = c_addr[7:2];
            m_nirq   = |(m_stat & m_ien);
            m_clr    = (m_commit && m_idx == 3 && c_strb[0]) ? c_data[3:0] : 4'h0;
            m_stat   = (m_stat & ~m_clr) | ch_done;
            m_start  = (m_commit && m_idx == 0 && c_strb[1]) ? c_data[11:8] : 4'h0;
            if (m_commit && m_idx == 0 && c_strb[0]) m_en = c_data[3:0];
            if (m_commit && m_idx == 2 && c_strb[0]) m_ien = c_data[3:0];
            if (m_commit && m_idx >= 4 && m_idx < 8)
                for (int b = 0; b < 2; b++)
                    if (c_strb[b]) m_cfg[m_idx-4][8*b +: 8] = c_data[8*b +: 8];
            m_irq = m_nirq;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("cmp_enable", ch_enable, m_en);
            chk("cmp_start", ch_start, m_start);
            chk("cmp_cfg", ch_cfg, {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]});
            chk("cmp_irq", irq, m_irq);
        end
    end

    int st_cnt [4] = '{default: 0};
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) st_cnt[i] += int'(ch_start[i]);
    end

    initial forever begin
        @(posedge clk);
        #1;
        ch_busy   = 4'($urandom);
        done_rand = (rand_en && $urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic exp_rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r, output logic ts);
        logic [5:0] i;
        i = a[7:2]; d = '0; r = 2'b00; ts = 1'b0;
        if (i == 0) d = {28'h0, m_en};
        else if (i == 1) d = {28'h0, ch_busy};
        else if (i == 2) d = {28'h0, m_ien};
        else if (i == 3) d = {28'h0, m_stat};
        else if (i >= 4 && i < 8) d = {16'h0, m_cfg[i-4]};
        else if (i == 15) d = 32'h4447_0001;
`ifdef AXIL_CTRL_REGS_TIMESTAMP_EN
        else if (i == 12 || i == 13) ts = 1'b1;
`endif
        else r = 2'b10;
    endtask

    // order: 0 = AW and W together, 1 = W two cycles before AW, 2 = AW two cycles before W.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int order, input logic [3:0] dn, output logic [1:0] resp);
        int   aw_t, w_t, k;
        logic aw_done, w_done, aw_f, w_f;
        aw_t = order == 1 ? 2 : 0;
        w_t  = order == 2 ? 2 : 0;
        aw_done = 1'b0; w_done = 1'b0; k = 0; resp = 2'b11;
        @(negedge clk);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        while (!(aw_done && w_done) && k < 40) begin
            s_axi_awvalid = !aw_done && k >= aw_t;
            s_axi_wvalid  = !w_done && k >= w_t;
            aw_f = s_axi_awvalid && s_axi_awready;
            w_f  = s_axi_wvalid && s_axi_wready;
            if ((aw_done || aw_f) && (w_done || w_f)) begin
                c_at = cyc + 1; c_addr = a; c_data = d; c_strb = s; done_force = dn;
            end
            aw_done = aw_done | aw_f;
            w_done  = w_done | w_f;
            @(negedge clk);
            k++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; done_force = 4'h0;
        if (!(aw_done && w_done)) begin
            chk("wr_timeout", 0, 1);
            return;
        end
        chk("bvalid_lat", s_axi_bvalid, 1);
        resp = s_axi_bresp;
        repeat ($urandom_range(0, 2)) begin
            chk("resp_no_accept", {s_axi_awready, s_axi_wready, s_axi_bvalid}, 3'b001);
            @(negedge clk);
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        chk("bvalid_drop", s_axi_bvalid, 0);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
        logic [31:0] ed;
        logic [1:0]  er;
        logic        ts, hit;
        int          k;
        ed = '0; er = '0; ts = 1'b0; hit = 1'b0; k = 0;
        @(negedge clk);
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        while (!hit && k < 40) begin
            if (s_axi_arready) begin
                hit = 1'b1;
                exp_rd(a, ed, er, ts);
            end
            @(negedge clk);
            k++;
        end
        s_axi_arvalid = 1'b0;
        d = s_axi_rdata; r = s_axi_rresp;
        if (!hit) begin
            chk("rd_timeout", 0, 1);
            return;
        end
        chk("rvalid_lat", s_axi_rvalid, 1);
        if (!ts) chk("rdata", s_axi_rdata, ed);
        chk("rresp", s_axi_rresp, er);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("rdata_hold", {s_axi_rvalid, s_axi_rdata}, {1'b1, d});
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        chk("rvalid_drop", s_axi_rvalid, 0);
    endtask

    task automatic do_reset();
        chk_on = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0; done_force = 4'h0;
        repeat (20) @(negedge clk);
        chk("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        chk("rst_valid", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        chk("rst_resp", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, 36'h0);
        chk("rst_chan", {ch_enable, ch_start, irq}, 9'h0);
        chk("rst_cfg", ch_cfg, 64'h0);
        resetn = 1'b1;
        @(negedge clk);
        chk_on = 1'b1;
        chk("post_rst", {ch_enable, ch_start, irq, ch_cfg}, 73'h0);
    endtask

    function automatic logic [11:0] rnd_addr();
        int i;
        i = $urandom_range(0, 20);
        if (i == 20) i = $urandom_range(16, 63);
        return {4'($urandom), 6'(i), 2'($urandom)};
    endfunction

    logic [31:0] rd, d2;
    logic [1:0]  r, r2, er;
    logic        ts_f;
    int          s0 [4];

    initial begin
        do_reset();
        axi_read(12'h03C, rd, r);
        chk("id", rd, 32'h4447_0001);
        chk("id_resp", r, 2'b00);

        axi_write(12'h000, 32'h3, 4'hF, 0, 4'h0, r);
        chk("en_same_cycle", ch_enable, 4'b0011);
        chk("model_en", m_en, 4'b0011);
        chk("bresp_ok", r, 2'b00);
        axi_write(12'h000, 32'h0, 4'hF, 2, 4'h0, r);
        chk("en_aw_first", ch_enable, 4'b0000);
        axi_write(12'h000, 32'h3, 4'hF, 1, 4'h0, r);
        chk("en_w_first", ch_enable, 4'b0011);
        chk("bresp_w_first", r, 2'b00);

        s0 = st_cnt;
        axi_write(12'h000, 32'h0000_0503, 4'hF, 0, 4'h0, r);
        chk("start_pulses", {st_cnt[3]-s0[3], st_cnt[2]-s0[2], st_cnt[1]-s0[1], st_cnt[0]-s0[0]},
            {32'd0, 32'd1, 32'd0, 32'd1});
        axi_read(12'h000, rd, r);
        chk("ctrl_readback", rd, 32'h0000_0003);

        axi_write(12'h008, 32'h1, 4'hF, 0, 4'h0, r);
        @(negedge clk); done_force = 4'b0001;
        @(negedge clk); done_force = 4'h0;
        chk("irq_lag", irq, 0);
        @(negedge clk);
        chk("irq_set", irq, 1);
        axi_write(12'h00C, 32'h1, 4'hF, 0, 4'h0, r);
        chk("irq_clr", irq, 0);
        @(negedge clk); done_force = 4'b0001;
        @(negedge clk); done_force = 4'h0;
        axi_write(12'h00C, 32'h1, 4'hF, 0, 4'b0001, r);
        axi_read(12'h00C, rd, r);
        chk("w1c_collide", rd, 32'h1);
        chk("irq_collide", irq, 1);

        axi_write(12'h01C, 32'hFFFF_1234, 4'b0001, 0, 4'h0, r);
        chk("cfg3_strb", ch_cfg[63:48], 16'h0034);
        axi_read(12'h01C, rd, r);
        chk("cfg3_read", rd, 32'h0000_0034);
        axi_write(12'h020, 32'hDEAD_BEEF, 4'hF, 0, 4'h0, r);
        chk("unmapped_bresp", r, 2'b10);
        axi_read(12'h020, rd, r);
        chk("unmapped_rdata", rd, 32'h0);
        chk("unmapped_rresp", r, 2'b10);
        axi_write(12'h03C, 32'h0, 4'hF, 0, 4'h0, r);
        chk("id_wr_resp", r, 2'b00);
        axi_read(12'h03C, rd, r);
        chk("id_after_wr", rd, 32'h4447_0001);

        rand_en = 1'b1;
        for (int it = 0; it < 250; it++) begin
            logic [11:0] wa, ra;
            int op;
            wa = rnd_addr(); ra = $urandom_range(0, 1) ? wa : rnd_addr();
            op = $urandom_range(0, 2);
            if (op == 0) axi_write(wa, $urandom, 4'($urandom), $urandom_range(0, 2), 4'h0, r);
            else if (op == 1) axi_read(ra, rd, r2);
            else fork
                axi_write(wa, $urandom, 4'($urandom), $urandom_range(0, 2), 4'h0, r);
                axi_read(ra, rd, r2);
            join
            if (op != 1) begin
                exp_rd(wa, d2, er, ts_f);
                chk("rand_bresp", r, er);
            end
        end
        rand_en = 1'b0;
        repeat (3) @(negedge clk);

        @(negedge clk);
        s_axi_awaddr = 12'h010; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        do_reset();
        axi_write(12'h010, 32'h0000_ABCD, 4'hF, 0, 4'h0, r);
        chk("cfg0_after_rst", ch_cfg[15:0], 16'hABCD);

`ifdef AXIL_CTRL_REGS_TIMESTAMP_EN
        begin
            logic [63:0] v1, v2;
            axi_read(12'h030, rd, r); v1[31:0] = rd;
            axi_read(12'h034, rd, r); v1[63:32] = rd;
            axi_read(12'h030, rd, r); v2[31:0] = rd;
            axi_read(12'h034, rd, r); v2[63:32] = rd;
            chk("ts_step", (v2 > v1) && (v2 - v1 < 64'd100), 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
